frame_buf_mgr: RTL and testbench
================================

Name: frame_buf_mgr

Overview:
Parametrised N-buffer frame-store address manager for the camera-to-DDR3-to-HDMI video path. It replaces the fixed 2-buffer ping-pong address logic with 2 to 4 buffers in DDR3. It tracks write-side bursts from the capture side and read-side bursts from the display side. It hands out DDR3 burst start addresses, and the reader always gets the most recently completed frame, never the buffer currently being written.

Parameters:
NUM_BUF, 3, number of frame buffers in DDR3 (legal 1..4)
ADDR_W, 28, DDR3 user address width
FRAME_SIZE, 786432, words per frame (1024x768)
BURST_LEN, 128, words per burst (H/8)
BASE_ADDR, 0, address of buffer 0

Ports:
clk  in  1  single clock for all logic
rst  in  1  reset, synchronous, active-high
pingpang_en  in  1  0 = all traffic uses buffer 0; 1 = multi-buffer rotation
wr_frame_start  in  1  1-cycle pulse, start of a captured frame (vsync edge)
wr_burst_done  in  1  1-cycle pulse, one write burst accepted by DDR3
rd_frame_start  in  1  1-cycle pulse, start of a display frame
rd_burst_done  in  1  1-cycle pulse, one read burst accepted
wr_addr  out  ADDR_W  start address of next write burst
rd_addr  out  ADDR_W  start address of next read burst
wr_buf_idx  out  2  buffer being written
rd_buf_idx  out  2  buffer being read
rd_valid  out  1  at least one complete frame has been committed
wr_frame_done  out  1  1-cycle pulse when a frame commits
wr_overrun  out  1  sticky: write bursts exceeded the frame
rd_wrap  out  1  1-cycle pulse when the read counter wraps
drop_cnt  out  8  saturating count of incomplete write frames

Behaviour:
- Reset: wr_addr = rd_addr = BASE_ADDR; wr_buf_idx = rd_buf_idx = 0; rd_valid, wr_frame_done, wr_overrun, rd_wrap = 0; drop_cnt = 0; latest invalid; write side disarmed.
- Constant NBURST = FRAME_SIZE/BURST_LEN. Elaboration error if FRAME_SIZE mod BURST_LEN != 0, or if BASE_ADDR + NUM_BUF*FRAME_SIZE > 2^ADDR_W.
- Address = BASE_ADDR + idx*FRAME_SIZE + cnt*BURST_LEN, computed at ADDR_W width. Output is registered and valid the cycle after the causing pulse (latency 1).
- Write side:
  - wr_burst_done is ignored until the first wr_frame_start arms the write side.
  - Armed: each wr_burst_done increments wr_cnt.
  - At wr_cnt == NBURST, further bursts are ignored and wr_overrun is set (sticky, cleared by the next wr_frame_start).
- On wr_frame_start, evaluated in this fixed order within one cycle:
  1. Commit. If wr_cnt == NBURST, then latest <= wr_buf_idx, rd_valid <= 1, and wr_frame_done pulses. Otherwise, if armed, drop_cnt increments (saturating at 255).
  2. Read select. If rd_frame_start is asserted in the same cycle, it sees the newly committed latest (bypass).
  3. Write select. Pick the lowest index that is neither the new latest nor the new rd_buf_idx. If no such index exists (NUM_BUF = 2 with reader on the other buffer, or NUM_BUF = 1), rewrite the current wr_buf_idx. Then wr_cnt <= 0.
- Read side:
  - On rd_frame_start: if latest is valid, rd_buf_idx <= latest; otherwise keep the current value. rd_cnt <= 0.
  - Each rd_burst_done increments rd_cnt. At NBURST-1, the next rd_burst_done wraps rd_cnt to 0 within the same buffer and pulses rd_wrap.
  - The read side runs even when rd_valid = 0 (outputs buffer 0 data).
- pingpang_en = 0: both sides are forced to buffer 0. Commit and rd_valid behave as normal.
  - A change of pingpang_en takes effect only at the next frame_start of each side.
- Simultaneous wr_burst_done and wr_frame_start: the burst is counted toward the old frame before the commit check.
- Simultaneous rd_burst_done and rd_frame_start: the frame start wins; rd_cnt = 0.
- Reset asserted mid-frame returns all state to reset values on the next edge. There is no partial commit.

Decomposition:
- Package frame_buf_pkg holds NBURST, the buffer-index type (2 bits), the address helper function buf_addr(idx, cnt), and the elaboration checks.
- Sub-module frame_addr_cnt is a burst counter plus address register with clamp/wrap mode select. It is instantiated twice: write side in clamp mode, read side in wrap mode.
- Buffer-selection logic stays in the top.

Test Plan:
Bench settings for all tests: FRAME_SIZE = 1024, BURST_LEN = 128 (NBURST = 8), NUM_BUF = 3, BASE_ADDR = 0.
1. After reset, send 8 wr_burst_done with no wr_frame_start -> wr_addr stays 0; rd_valid = 0.
2. wr_frame_start, 8 bursts -> wr_addr steps 0, 128, ..., 896. Next wr_frame_start -> wr_frame_done pulses, rd_valid = 1, wr_buf_idx = 1, wr_addr = 1024.
3. Continuing from test 2 (latest = 0), rd_frame_start and wr_frame_start in the same cycle, with buffer 1 full -> rd_buf_idx = 1, wr_buf_idx = 0, wr_addr = 0.
4. Only 5 bursts, then wr_frame_start -> no commit, drop_cnt = 1, latest unchanged. Then 9 bursts -> wr_addr clamps at 896 and wr_overrun = 1.
5. 8 rd_burst_done on buffer 2 -> rd_addr = 2048, ..., 2944. The 8th pulse gives rd_addr = 2048 and rd_wrap pulses.
6. pingpang_en = 0, two complete frames -> wr_buf_idx = rd_buf_idx = 0 throughout; rd_valid = 1. Reset mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the N-buffer frame-store address manager.
// Frame geometry arrives as arguments so one package serves every instance.
package frame_buf_pkg;

    typedef logic [1:0] buf_idx_t;

    localparam int unsigned MaxBuf = 4;

    // NBURST: bursts per frame.
    function automatic int unsigned nburst(input int unsigned frame_size,
                                           input int unsigned burst_len);
        return frame_size / burst_len;
    endfunction

    // Start address of burst cnt in buffer idx.
    function automatic longint unsigned buf_addr(input longint unsigned base,
                                                 input int unsigned     frame_size,
                                                 input int unsigned     burst_len,
                                                 input buf_idx_t        idx,
                                                 input int unsigned     cnt);
        return base + 64'(idx) * 64'(frame_size) + 64'(cnt) * 64'(burst_len);
    endfunction

    // Elaboration-time legality of a buffer configuration.
    function automatic bit cfg_ok(input int unsigned     num_buf,
                                  input int unsigned     addr_w,
                                  input int unsigned     frame_size,
                                  input int unsigned     burst_len,
                                  input longint unsigned base);
        longint unsigned span;
        if (num_buf < 1 || num_buf > MaxBuf) return 1'b0;
        if (burst_len == 0 || frame_size < burst_len) return 1'b0;
        if (frame_size % burst_len != 0) return 1'b0;
        if (addr_w == 0 || addr_w > 62) return 1'b0;
        span = base + 64'(num_buf) * 64'(frame_size);
        return span <= (64'd1 << addr_w);
    endfunction

endpackage

// File: rtl/frame_buf_mgr_if.sv
// Capture/display-side handshake bundle for the frame buffer manager.
interface frame_buf_mgr_if #(
    parameter int unsigned ADDR_W = 28
);
    import frame_buf_pkg::*;

    logic              pingpang_en;
    logic              wr_frame_start;
    logic              wr_burst_done;
    logic              rd_frame_start;
    logic              rd_burst_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    buf_idx_t          wr_buf_idx;
    buf_idx_t          rd_buf_idx;
    logic              rd_valid;
    logic              wr_frame_done;
    logic              wr_overrun;
    logic              rd_wrap;
    logic [7:0]        drop_cnt;

    modport master (
        output pingpang_en, wr_frame_start, wr_burst_done, rd_frame_start, rd_burst_done,
        input  wr_addr, rd_addr, wr_buf_idx, rd_buf_idx, rd_valid, wr_frame_done,
        input  wr_overrun, rd_wrap, drop_cnt
    );

    modport slave (
        input  pingpang_en, wr_frame_start, wr_burst_done, rd_frame_start, rd_burst_done,
        output wr_addr, rd_addr, wr_buf_idx, rd_buf_idx, rd_valid, wr_frame_done,
        output wr_overrun, rd_wrap, drop_cnt
    );

endinterface

// File: rtl/frame_addr_cnt.sv
// Burst counter plus registered burst start address. Clamp mode saturates at
// NBURST (frame complete); wrap mode cycles 0..NBURST-1 within the same buffer.
module frame_addr_cnt
    import frame_buf_pkg::*;
#(
    parameter int unsigned     ADDR_W     = 28,
    parameter int unsigned     FRAME_SIZE = 786432,
    parameter int unsigned     BURST_LEN  = 128,
    parameter longint unsigned BASE_ADDR  = 0,
    parameter bit              WRAP       = 1'b0,
    localparam int unsigned    NB         = nburst(FRAME_SIZE, BURST_LEN),
    localparam int unsigned    CNT_W      = $clog2(NB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    input  buf_idx_t          idx,
    output logic              full,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [CNT_W-1:0] Last = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] Top  = CNT_W'(NB);

    logic [CNT_W-1:0]  cnt_q, cnt_upd, cnt_d, addr_cnt;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // hit: clamp mode = burst refused at NBURST; wrap mode = counter wrapped.
    always_comb begin
        cnt_upd = cnt_q;
        hit     = 1'b0;
        if (inc) begin
            if (WRAP) begin
                if (cnt_q == Last) begin
                    cnt_upd = '0;
                    hit     = 1'b1;
                end else begin
                    cnt_upd = cnt_q + 1'b1;
                end
            end else if (cnt_q == Top) begin
                hit = 1'b1;
            end else begin
                cnt_upd = cnt_q + 1'b1;
            end
        end
        full     = (cnt_upd == Top);
        cnt_d    = clear ? '0 : cnt_upd;
        // A full frame keeps pointing at its last burst, never into the next buffer.
        addr_cnt = (cnt_d == Top) ? Last : cnt_d;
        addr_d   = ADDR_W'(buf_addr(BASE_ADDR, FRAME_SIZE, BURST_LEN, idx, 32'(addr_cnt)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/frame_buf_mgr.sv
// N-buffer frame-store address manager: the reader always follows the latest
// committed frame and the writer never lands on the latest or displayed buffer.
module frame_buf_mgr
    import frame_buf_pkg::*;
#(
    parameter int unsigned     NUM_BUF    = 3,
    parameter int unsigned     ADDR_W     = 28,
    parameter int unsigned     FRAME_SIZE = 786432,
    parameter int unsigned     BURST_LEN  = 128,
    parameter longint unsigned BASE_ADDR  = 0
) (
    input logic            clk,
    input logic            rst,
    frame_buf_mgr_if.slave bus
);

    if (!cfg_ok(NUM_BUF, ADDR_W, FRAME_SIZE, BURST_LEN, BASE_ADDR)) begin : g_cfg_err
        $error("frame_buf_mgr: illegal buffer geometry");
    end

    buf_idx_t   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, latest_q, latest_d;
    logic       valid_q, valid_d, armed_q, done_q, overrun_q, wrap_q;
    logic [7:0] drop_q;
    logic       wr_inc, wr_full, wr_hit, rd_hit, commit, unused_rd_full;

    assign wr_inc = bus.wr_burst_done & armed_q;
    assign commit = bus.wr_frame_start & wr_full;

    // Commit, then read select (bypassing the new latest), then write select.
    always_comb begin
        latest_d = commit ? wr_idx_q : latest_q;
        valid_d  = valid_q | commit;

        rd_idx_d = rd_idx_q;
        if (bus.rd_frame_start) begin
            if (!bus.pingpang_en) begin
                rd_idx_d = '0;
            end else if (valid_d) begin
                rd_idx_d = latest_d;
            end
        end

        // Descending scan so the lowest free index wins; none free keeps the current one.
        wr_idx_d = wr_idx_q;
        if (bus.wr_frame_start) begin
            if (!bus.pingpang_en) begin
                wr_idx_d = '0;
            end else begin
                for (int i = int'(NUM_BUF) - 1; i >= 0; i--) begin
                    if (!valid_d || (buf_idx_t'(i) != latest_d && buf_idx_t'(i) != rd_idx_d)) begin
                        wr_idx_d = buf_idx_t'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            latest_q  <= '0;
            valid_q   <= 1'b0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wrap_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            latest_q <= latest_d;
            valid_q  <= valid_d;
            armed_q  <= armed_q | bus.wr_frame_start;
            done_q   <= commit;
            wrap_q   <= rd_hit & ~bus.rd_frame_start;
            if (bus.wr_frame_start) begin
                overrun_q <= 1'b0;
            end else if (wr_hit) begin
                overrun_q <= 1'b1;
            end
            if (bus.wr_frame_start && armed_q && !wr_full && drop_q != 8'hff) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    frame_addr_cnt #(
        .ADDR_W     (ADDR_W),
        .FRAME_SIZE (FRAME_SIZE),
        .BURST_LEN  (BURST_LEN),
        .BASE_ADDR  (BASE_ADDR),
        .WRAP       (1'b0)
    ) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.wr_frame_start),
        .inc   (wr_inc),
        .idx   (wr_idx_d),
        .full  (wr_full),
        .hit   (wr_hit),
        .addr  (bus.wr_addr)
    );

    frame_addr_cnt #(
        .ADDR_W     (ADDR_W),
        .FRAME_SIZE (FRAME_SIZE),
        .BURST_LEN  (BURST_LEN),
        .BASE_ADDR  (BASE_ADDR),
        .WRAP       (1'b1)
    ) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.rd_frame_start),
        .inc   (bus.rd_burst_done),
        .idx   (rd_idx_d),
        .full  (unused_rd_full),
        .hit   (rd_hit),
        .addr  (bus.rd_addr)
    );

    assign bus.wr_buf_idx    = wr_idx_q;
    assign bus.rd_buf_idx    = rd_idx_q;
    assign bus.rd_valid      = valid_q;
    assign bus.wr_frame_done = done_q;
    assign bus.wr_overrun    = overrun_q;
    assign bus.rd_wrap       = wrap_q;
    assign bus.drop_cnt      = drop_q;

endmodule

// File: tb/tb_frame_buf_mgr.sv
// Directed plus randomized bench for frame_buf_mgr against a frame-level model
// (3 buffers of 1024 words, 128-word bursts).
module tb_frame_buf_mgr;

    localparam int unsigned NumBuf    = 3;
    localparam int unsigned AddrW     = 28;
    localparam int unsigned FrameSize = 1024;
    localparam int unsigned BurstLen  = 128;
    localparam int          NB        = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   pp  = 1'b1;
    int   tests = 0;
    int   fails = 0;

    frame_buf_mgr_if #(.ADDR_W(AddrW)) bus ();

    frame_buf_mgr #(
        .NUM_BUF    (NumBuf),
        .ADDR_W     (AddrW),
        .FRAME_SIZE (FrameSize),
        .BURST_LEN  (BurstLen),
        .BASE_ADDR  (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: latest = -1 means no frame committed yet.
    bit m_armed, m_done, m_over, m_wrap;
    int m_wcnt, m_rcnt, m_wbuf, m_rbuf, m_latest, m_drop;

    task automatic m_reset();
        m_armed = 0; m_done = 0; m_over = 0; m_wrap = 0;
        m_wcnt = 0; m_rcnt = 0; m_wbuf = 0; m_rbuf = 0; m_latest = -1; m_drop = 0;
    endtask

    task automatic m_step(input bit p, input bit wfs, input bit wbd, input bit rfs, input bit rbd);
        bit over_hit = 0;
        bit wrap_hit = 0;
        m_done = 0;
        if (wbd && m_armed) begin
            if (m_wcnt == NB) over_hit = 1;
            else m_wcnt++;
        end
        if (rbd) begin
            m_rcnt++;
            if (m_rcnt == NB) begin m_rcnt = 0; wrap_hit = 1; end
        end
        if (wfs) begin
            if (m_wcnt == NB) begin m_latest = m_wbuf; m_done = 1; end
            else if (m_armed && m_drop < 255) m_drop++;
        end
        if (rfs) begin
            if (!p) m_rbuf = 0;
            else if (m_latest >= 0) m_rbuf = m_latest;
            m_rcnt = 0;
            wrap_hit = 0;
        end
        if (wfs) begin
            if (!p) m_wbuf = 0;
            else begin
                for (int i = 0; i < int'(NumBuf); i++) begin
                    if (m_latest < 0 || (i != m_latest && i != m_rbuf)) begin
                        m_wbuf = i;
                        break;
                    end
                end
            end
            m_wcnt = 0; m_armed = 1; m_over = 0;
        end else if (over_hit) begin
            m_over = 1;
        end
        m_wrap = wrap_hit;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int wc = (m_wcnt < NB) ? m_wcnt : NB - 1;
        chk("wr_addr", 64'(bus.wr_addr), 64'(m_wbuf * FrameSize + wc * BurstLen));
        chk("rd_addr", 64'(bus.rd_addr), 64'(m_rbuf * FrameSize + m_rcnt * BurstLen));
        chk("wr_buf_idx", 64'(bus.wr_buf_idx), 64'(m_wbuf));
        chk("rd_buf_idx", 64'(bus.rd_buf_idx), 64'(m_rbuf));
        chk("rd_valid", 64'(bus.rd_valid), 64'(m_latest >= 0));
        chk("wr_frame_done", 64'(bus.wr_frame_done), 64'(m_done));
        chk("wr_overrun", 64'(bus.wr_overrun), 64'(m_over));
        chk("rd_wrap", 64'(bus.rd_wrap), 64'(m_wrap));
        chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
    endtask

    task automatic step(input bit wfs, input bit wbd, input bit rfs, input bit rbd);
        bus.pingpang_en    = pp;
        bus.wr_frame_start = wfs;
        bus.wr_burst_done  = wbd;
        bus.rd_frame_start = rfs;
        bus.rd_burst_done  = rbd;
        if (rst) m_reset();
        else m_step(pp, wfs, wbd, rfs, rbd);
        @(posedge clk);
        #1;
        bus.wr_frame_start = 0;
        bus.wr_burst_done  = 0;
        bus.rd_frame_start = 0;
        bus.rd_burst_done  = 0;
        check_all();
    endtask

    task automatic wr_bursts(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    initial begin
        bus.pingpang_en = 1; bus.wr_frame_start = 0; bus.wr_burst_done = 0;
        bus.rd_frame_start = 0; bus.rd_burst_done = 0;
        m_reset();
        step(0, 0, 0, 0);
        rst = 0;

        // 1: bursts before arming are ignored
        wr_bursts(8);
        chk("t1_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("t1_rd_valid", 64'(bus.rd_valid), 64'd0);

        // 2: first frame into buffer 0, commit moves writer to buffer 1
        step(1, 0, 0, 0);
        wr_bursts(7);
        chk("t2_wr_addr_last", 64'(bus.wr_addr), 64'd896);
        wr_bursts(1);
        chk("t2_wr_addr_clamp", 64'(bus.wr_addr), 64'd896);
        step(1, 0, 0, 0);
        chk("t2_done", 64'(bus.wr_frame_done), 64'd1);
        chk("t2_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("t2_wr_buf", 64'(bus.wr_buf_idx), 64'd1);
        chk("t2_wr_addr", 64'(bus.wr_addr), 64'd1024);

        // 3: simultaneous read/write frame start sees the new latest
        wr_bursts(8);
        step(1, 0, 1, 0);
        chk("t3_rd_buf", 64'(bus.rd_buf_idx), 64'd1);
        chk("t3_wr_buf", 64'(bus.wr_buf_idx), 64'd0);
        chk("t3_wr_addr", 64'(bus.wr_addr), 64'd0);

        // 4: short frame drops, then overrun
        wr_bursts(5);
        step(1, 0, 0, 0);
        chk("t4_drop", 64'(bus.drop_cnt), 64'd1);
        chk("t4_no_done", 64'(bus.wr_frame_done), 64'd0);
        wr_bursts(9);
        chk("t4_wr_addr", 64'(bus.wr_addr), 64'd896);
        chk("t4_overrun", 64'(bus.wr_overrun), 64'd1);

        // 5: get buffer 2 committed, read it through a wrap
        step(1, 0, 0, 0);
        chk("t5_overrun_clr", 64'(bus.wr_overrun), 64'd0);
        chk("t5_wr_buf2", 64'(bus.wr_buf_idx), 64'd2);
        wr_bursts(8);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("t5_rd_buf", 64'(bus.rd_buf_idx), 64'd2);
        chk("t5_rd_addr0", 64'(bus.rd_addr), 64'd2048);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        chk("t5_rd_addr7", 64'(bus.rd_addr), 64'd2944);
        step(0, 0, 0, 1);
        chk("t5_rd_wrap_addr", 64'(bus.rd_addr), 64'd2048);
        chk("t5_rd_wrap", 64'(bus.rd_wrap), 64'd1);
        step(0, 0, 1, 1);
        chk("t5_rd_start_wins", 64'(bus.rd_addr), 64'd2048);

        // 6: single-buffer mode, then reset mid-frame
        pp = 0;
        step(1, 0, 1, 0);
        for (int f = 0; f < 2; f++) begin
            wr_bursts(8);
            step(1, 0, 0, 0);
            chk("t6_wr_buf", 64'(bus.wr_buf_idx), 64'd0);
            chk("t6_rd_buf", 64'(bus.rd_buf_idx), 64'd0);
            chk("t6_rd_valid", 64'(bus.rd_valid), 64'd1);
        end
        wr_bursts(3);
        step(0, 0, 0, 1);
        rst = 1;
        step(1, 1, 1, 1);
        rst = 0;
        chk("t6_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("t6_rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("t6_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("t6_rst_drop", 64'(bus.drop_cnt), 64'd0);
        wr_bursts(2);
        chk("t6_rst_disarmed", 64'(bus.wr_addr), 64'd0);

        // Randomized traffic
        pp = 1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(99) < 2) pp = ~pp;
            rst = ($urandom_range(299) == 0);
            step(1'($urandom_range(99) < 5), 1'($urandom_range(1)),
                 1'($urandom_range(99) < 4), 1'($urandom_range(1)));
        end
        rst = 0;
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
